// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Purpose : shared VGA 640x480@60 timing constants, field widths, 3-bit RGB
//           colour constants and the pattern-select FSM state type.
// Ports   : none (package).
// ---------------------------------------------------------------------------
package vga_pkg;

  // Horizontal timing in pixel ticks: active / front porch / sync / back porch
  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;

  // Vertical timing in lines: active / front porch / sync / back porch
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;

  // Field widths
  localparam int unsigned CNT_W  = 10;
  localparam int unsigned ROW_W  = 9;
  localparam int unsigned COL_W  = 10;
  localparam int unsigned RGB_W  = 3;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned FCNT_W = 8;

  // Colours, bit order {R,G,B}
  localparam logic [RGB_W-1:0] BLACK   = 3'b000;
  localparam logic [RGB_W-1:0] BLUE    = 3'b001;
  localparam logic [RGB_W-1:0] GREEN   = 3'b010;
  localparam logic [RGB_W-1:0] CYAN    = 3'b011;
  localparam logic [RGB_W-1:0] RED     = 3'b100;
  localparam logic [RGB_W-1:0] MAGENTA = 3'b101;
  localparam logic [RGB_W-1:0] YELLOW  = 3'b110;
  localparam logic [RGB_W-1:0] WHITE   = 3'b111;

  // SHOW: no change pending; PEND: an advance is latched for the next boundary
  typedef enum logic {
    SHOW = 1'b0,
    PEND = 1'b1
  } sel_state_t;

  // Next pattern index; the 2-bit add wraps 3 -> 0 naturally
  function automatic logic [SEL_W-1:0] next_patt(input logic [SEL_W-1:0] sel);
    return sel + SEL_W'(1);
  endfunction

endpackage

// File: rtl/vga_timing.sv
// ---------------------------------------------------------------------------
// vga_timing
// Purpose : horizontal/vertical pixel counters and sync/visible decode.
//           Geometry defaults to the vga_pkg 640x480 constants.
// Ports   : clk_i, rst_i (async, active-high), pix_en_i (pixel tick)
//           hcnt_o, vcnt_o   registered counters
//           visible_c        combinational: inside active window
//           hsync_c, vsync_c combinational active-low sync for current count
//           frame_end_c      combinational: pixel tick on last pixel of frame
// ---------------------------------------------------------------------------
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned HACT = H_ACTIVE,
  parameter int unsigned HFP  = H_FP,
  parameter int unsigned HSW  = H_SYNC,
  parameter int unsigned HBP  = H_BP,
  parameter int unsigned VACT = V_ACTIVE,
  parameter int unsigned VFP  = V_FP,
  parameter int unsigned VSW  = V_SYNC,
  parameter int unsigned VBP  = V_BP
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             pix_en_i,
  output logic [CNT_W-1:0] hcnt_o,
  output logic [CNT_W-1:0] vcnt_o,
  output logic             visible_c,
  output logic             hsync_c,
  output logic             vsync_c,
  output logic             frame_end_c
);

  localparam int unsigned HTOT = HACT + HFP + HSW + HBP;
  localparam int unsigned VTOT = VACT + VFP + VSW + VBP;

  logic [CNT_W-1:0] r_hcnt;
  logic [CNT_W-1:0] r_vcnt;
  logic             w_h_last;
  logic             w_v_last;

  assign w_h_last = (r_hcnt == CNT_W'(HTOT - 1));
  assign w_v_last = (r_vcnt == CNT_W'(VTOT - 1));

  // Pixel/line counters, advancing only on pixel ticks
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (pix_en_i) begin
      if (w_h_last) begin
        r_hcnt <= '0;
        r_vcnt <= w_v_last ? '0 : r_vcnt + CNT_W'(1);
      end else begin
        r_hcnt <= r_hcnt + CNT_W'(1);
      end
    end
  end

  // Sync and window decode
  always_comb begin
    visible_c   = (r_hcnt < CNT_W'(HACT)) && (r_vcnt < CNT_W'(VACT));
    hsync_c     = !((r_hcnt >= CNT_W'(HACT + HFP)) &&
                    (r_hcnt <  CNT_W'(HACT + HFP + HSW)));
    vsync_c     = !((r_vcnt >= CNT_W'(VACT + VFP)) &&
                    (r_vcnt <  CNT_W'(VACT + VFP + VSW)));
    frame_end_c = pix_en_i && w_h_last && w_v_last;
  end

  assign hcnt_o = r_hcnt;
  assign vcnt_o = r_vcnt;

endmodule

// File: rtl/vga_patt_ctrl.sv
// ---------------------------------------------------------------------------
// vga_patt_ctrl
// Purpose : VGA pattern controller. Picks one of four pattern generators,
//           advancing on manual request or every AUTO_FRAMES frames, only at
//           frame boundaries. Blanks and registers the selected pixel.
// Config  : define BORDER_EN to paint a white one-pixel frame around the
//           visible area; undefined shows the pattern unmodified.
// Ports   : clk_i, rst_i (async, active-high), pix_en_i (pixel tick)
//           next_i  one-cycle advance request;  auto_i  auto-cycle enable
//           patt0_i..patt3_i  RGB from generators (driven from row_o/colum_o)
//           row_o, colum_o    combinational active coordinates, 0 in blanking
//           rgb_o, hsync_o, vsync_o  registered, mutually aligned
//           patt_sel_o        displayed pattern index
//           frame_o           combinational pulse on the frame-boundary tick
// Geometry parameters default to vga_pkg and exist so a reduced raster can
// be elaborated.
// ---------------------------------------------------------------------------
module vga_patt_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned AUTO_FRAMES = 120,
  parameter int unsigned HACT        = H_ACTIVE,
  parameter int unsigned HFP         = H_FP,
  parameter int unsigned HSW         = H_SYNC,
  parameter int unsigned HBP         = H_BP,
  parameter int unsigned VACT        = V_ACTIVE,
  parameter int unsigned VFP         = V_FP,
  parameter int unsigned VSW         = V_SYNC,
  parameter int unsigned VBP         = V_BP
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             pix_en_i,
  input  logic             next_i,
  input  logic             auto_i,
  input  logic [RGB_W-1:0] patt0_i,
  input  logic [RGB_W-1:0] patt1_i,
  input  logic [RGB_W-1:0] patt2_i,
  input  logic [RGB_W-1:0] patt3_i,
  output logic [ROW_W-1:0] row_o,
  output logic [COL_W-1:0] colum_o,
  output logic [RGB_W-1:0] rgb_o,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic [SEL_W-1:0] patt_sel_o,
  output logic             frame_o
);

  logic [CNT_W-1:0]  w_hcnt;
  logic [CNT_W-1:0]  w_vcnt;
  logic              w_visible;
  logic              w_hsync;
  logic              w_vsync;
  logic              w_frame_end;

  sel_state_t        r_state;
  logic [SEL_W-1:0]  r_sel;
  logic [FCNT_W-1:0] r_fcnt;
  logic [RGB_W-1:0]  r_rgb;
  logic              r_hsync;
  logic              r_vsync;

  logic              w_auto_req;
  logic              w_manual;
  logic              w_advance;
  logic              w_border;
  logic [RGB_W-1:0]  w_patt;
  logic [RGB_W-1:0]  w_pixel;

  vga_timing #(
    .HACT (HACT),
    .HFP  (HFP),
    .HSW  (HSW),
    .HBP  (HBP),
    .VACT (VACT),
    .VFP  (VFP),
    .VSW  (VSW),
    .VBP  (VBP)
  ) u_timing (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .pix_en_i    (pix_en_i),
    .hcnt_o      (w_hcnt),
    .vcnt_o      (w_vcnt),
    .visible_c   (w_visible),
    .hsync_c     (w_hsync),
    .vsync_c     (w_vsync),
    .frame_end_c (w_frame_end)
  );

  // Advance sources at a boundary: latched or same-cycle manual, and the
  // auto counter expiring. Any combination yields exactly one step.
  always_comb begin
    w_auto_req = w_frame_end && auto_i && (r_fcnt == FCNT_W'(AUTO_FRAMES - 1));
    w_manual   = (r_state == PEND) || next_i;
    w_advance  = w_frame_end && (w_manual || w_auto_req);
  end

  // Selection FSM and auto frame counter. next_i is latched on any clock so
  // a single-cycle pulse between pixel ticks is not lost; the selection
  // itself only moves on the frame-boundary pixel tick.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= SHOW;
      r_sel   <= '0;
      r_fcnt  <= '0;
    end else if (w_frame_end) begin
      r_state <= SHOW;
      if (w_advance) begin
        r_sel <= next_patt(r_sel);
      end
      if (!auto_i || w_manual || w_auto_req) begin
        r_fcnt <= '0;
      end else begin
        r_fcnt <= r_fcnt + FCNT_W'(1);
      end
    end else begin
      if (next_i) begin
        r_state <= PEND;
      end
      if (pix_en_i && !auto_i) begin
        r_fcnt <= '0;
      end
    end
  end

  // Pattern mux
  always_comb begin
    w_patt = patt0_i;
    case (r_sel)
      2'd0:    w_patt = patt0_i;
      2'd1:    w_patt = patt1_i;
      2'd2:    w_patt = patt2_i;
      default: w_patt = patt3_i;
    endcase
  end

`ifdef BORDER_EN
  assign w_border = (w_hcnt == CNT_W'(0)) || (w_hcnt == CNT_W'(HACT - 1)) ||
                    (w_vcnt == CNT_W'(0)) || (w_vcnt == CNT_W'(VACT - 1));
`else
  assign w_border = 1'b0;
`endif

  assign w_pixel = !w_visible ? BLACK : (w_border ? WHITE : w_patt);

  // One-tick output stage; syncs ride along so they stay aligned with rgb_o
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rgb   <= BLACK;
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
    end else if (pix_en_i) begin
      r_rgb   <= w_pixel;
      r_hsync <= w_hsync;
      r_vsync <= w_vsync;
    end
  end

  assign row_o      = w_visible ? ROW_W'(w_vcnt) : '0;
  assign colum_o    = w_visible ? COL_W'(w_hcnt) : '0;
  assign rgb_o      = r_rgb;
  assign hsync_o    = r_hsync;
  assign vsync_o    = r_vsync;
  assign patt_sel_o = r_sel;
  assign frame_o    = w_frame_end;

endmodule

// File: doc/vga_patt_ctrl.md
VGA_PATT_CTRL -- requirements
Module: vga_patt_ctrl

Interface
REQ-001 SHALL have parameter AUTO_FRAMES, default 120: frames per pattern in auto mode (legal range 1..255).
REQ-002 SHALL have port clk_i, input, 1: system clock.
REQ-003 SHALL have port rst_i, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port pix_en_i, input, 1: pixel tick (25 MHz enable); all state advances only when it is high.
REQ-005 SHALL have port next_i, input, 1: single-cycle request to advance to the next pattern.
REQ-006 SHALL have port auto_i, input, 1: 1 = auto-cycle patterns; 0 = manual only.
REQ-007 SHALL have ports patt0_i, patt1_i, patt2_i and patt3_i, each input, 3: RGB from four pattern generators, combinational on row_o/colum_o.
REQ-008 SHALL have port row_o, output, 9: active row 0..479, forced to 0 in blanking.
REQ-009 SHALL have port colum_o, output, 10: active column 0..639, forced to 0 in blanking.
REQ-010 SHALL have port rgb_o, output, 3: selected, blanked pixel.
REQ-011 SHALL have port hsync_o, output, 1: active-low horizontal sync.
REQ-012 SHALL have port vsync_o, output, 1: active-low vertical sync.
REQ-013 SHALL have port patt_sel_o, output, 2: index of the pattern currently displayed.
REQ-014 SHALL have port frame_o, output, 1: one-clock pulse at frame wrap.

Function
REQ-015 SHALL keep a 10-bit hcnt over 0..799 and a 10-bit vcnt over 0..524; hcnt increments on pix_en_i, wraps 799->0 and increments vcnt; vcnt wraps 524->0.
REQ-016 SHALL define visible as hcnt<640 and vcnt<480.
REQ-017 SHALL define hsync active (0) for hcnt 656..751 and vsync active (0) for vcnt 490..491.
REQ-018 SHALL drive row_o/colum_o combinationally from vcnt/hcnt (0 when not visible).
REQ-019 SHALL register rgb_o on pix_en_i from patt[patt_sel]_i when visible, else 000, and SHALL delay hsync_o/vsync_o by the same one tick so all three stay aligned.
REQ-020 SHALL pulse frame_o in the clock where pix_en_i is high with hcnt=799 and vcnt=524 (frame boundary).
REQ-021 SHALL implement a select FSM with two states: SHOW (no change pending) and PEND (advance latched).
REQ-022 SHALL latch next_i from any state to PEND; a repeated next_i in PEND SHALL NOT queue a second advance.
REQ-023 SHALL keep an 8-bit frame counter that increments at each frame boundary while auto_i=1; on reaching AUTO_FRAMES-1 it SHALL reset to 0 and request an advance.
REQ-024 SHALL advance patt_sel by exactly one (3->0 wrap) only at a frame boundary, then return to SHOW; a coinciding manual and auto request SHALL advance once.
REQ-025 SHALL clear the frame counter when auto_i=0 or on any manual advance.
REQ-026 SHALL hold patt_sel constant mid-frame, so no frame mixes patterns.

Reset
REQ-027 SHALL, on rst_i high, immediately set hcnt=0, vcnt=0, frame counter=0, patt_sel=0, state SHOW, rgb_o=000, hsync_o=1, vsync_o=1, frame_o=0.
REQ-028 SHALL discard a pending request when reset asserts mid-frame, and SHALL start a fresh frame at hcnt=0, vcnt=0 after release.

Configuration
REQ-029 SHALL, with BORDER_EN defined, force rgb_o=111 on visible pixels where column is 0 or 639 or row is 0 or 479.
REQ-030 SHALL, without BORDER_EN, show the selected pattern unmodified on every visible pixel.

Structure
REQ-031 SHALL take timing constants (640/16/96/48, 480/10/2/33) and colour constants BLACK..WHITE from shared package vga_pkg.
REQ-032 SHALL place the counters and sync decode in sub-module vga_timing; selection FSM, mux and blanking SHALL stay in vga_patt_ctrl.

Verification
REQ-033 SHALL verify sync timing: free-run with pix_en_i every 4th clock -> hsync_o low 96 ticks per 800-tick line, vsync_o low 2 lines per 525, frame_o once per 420000 ticks.
REQ-034 SHALL verify blanking: patt0_i=111 constant -> rgb_o=111 only for the 640x480 visible window, 000 elsewhere, one tick behind colum_o.
REQ-035 SHALL verify manual advance: pulse next_i at vcnt=100, auto_i=0 -> patt_sel_o stays 0 until the boundary, then becomes 1; a second pulse at vcnt=200 of the same frame gives 1 only.
REQ-036 SHALL verify auto wrap and coincidence: AUTO_FRAMES=2, auto_i=1 -> patt_sel_o 0,0,1,1,2,2,3,3,0 per frame; next_i on the auto frame advances by one only.
REQ-037 SHALL verify reset mid-frame: rst_i at hcnt=300, vcnt=200 with PEND -> outputs at reset values, patt_sel_o=0, no advance at the next boundary.
REQ-038 SHALL verify BORDER_EN: with the macro defined and patt0_i=001 -> rgb_o=111 at (0,0), (639,479) and (320,0); 001 at (320,240).
